// File: rtl/crc_serial_engine.sv
// Serial CRC engine: any width/polynomial, framed, with generate (serial append) and check modes.
// Serial clock and frame controls are edge-detected in the masterClk domain.
module crc_serial_engine #(
  parameter int                   CRC_WIDTH = 4,
  parameter logic [CRC_WIDTH-1:0] POLY      = 4'b0011,
  parameter logic [CRC_WIDTH-1:0] INIT      = '0,
  parameter int                   CNT_WIDTH = 8
) (
  input  logic                 masterClk,
  input  logic                 reset,
  input  logic                 serialClk,
  input  logic                 serialData,
  input  logic                 enable,
  input  logic                 frameStart,
  input  logic                 frameEnd,
  input  logic                 mode,
  output logic [CRC_WIDTH-1:0] crc,
  output logic                 crcOut,
  output logic                 crcOutValid,
  output logic [CNT_WIDTH-1:0] bitCount,
  output logic                 checkDone,
  output logic                 checkOk,
  output logic                 busy
);

  localparam int             AW       = (CRC_WIDTH > 2) ? $clog2(CRC_WIDTH) : 1;
  localparam logic [AW-1:0]  APP_LAST = AW'(CRC_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_APPEND, S_CHECK} state_t;

  state_t               r_state, w_state_next;
  logic                 r_prev_sclk, r_prev_fs, r_prev_fe;
  logic                 r_mode;
  logic [CRC_WIDTH-1:0] r_crc;
  logic [CNT_WIDTH-1:0] r_bit_cnt;
  logic [AW-1:0]        r_app_cnt;
  logic                 r_crc_out, r_crc_out_valid;
  logic                 r_check_done, r_check_ok;

  logic                 w_sclk_edge, w_fs_edge, w_fe_edge;
  logic                 w_fb, w_app_last;
  logic [CRC_WIDTH-1:0] w_shift, w_crc_upd, w_crc_accum;

  assign w_sclk_edge = serialClk  & ~r_prev_sclk;
  assign w_fs_edge   = frameStart & ~r_prev_fs;
  assign w_fe_edge   = frameEnd   & ~r_prev_fe;

  assign w_shift     = {r_crc[CRC_WIDTH-2:0], 1'b0};
  assign w_fb        = serialData ^ r_crc[CRC_WIDTH-1];
  assign w_crc_upd   = enable ? (w_shift ^ (w_fb ? POLY : '0)) : w_shift;
  // A bit arriving together with frameEnd is folded in before the append starts.
  assign w_crc_accum = w_sclk_edge ? w_crc_upd : r_crc;
  assign w_app_last  = (r_app_cnt == APP_LAST);

  // Previous-value registers reset high so a level already high at release is not an edge.
  always_ff @(posedge masterClk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_prev_sclk <= 1'b1;
      r_prev_fs   <= 1'b1;
      r_prev_fe   <= 1'b1;
      r_state     <= S_IDLE;
    end else begin
      r_prev_sclk <= serialClk;
      r_prev_fs   <= frameStart;
      r_prev_fe   <= frameEnd;
      r_state     <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves w_state_next unassigned (no latch).
    w_state_next = r_state;
    if (w_fs_edge) begin
      w_state_next = S_ACCUM;
    end else begin
      unique case (r_state)
        S_IDLE:   w_state_next = S_IDLE;
        S_ACCUM:  if (w_fe_edge) w_state_next = r_mode ? S_CHECK : S_APPEND;
        S_APPEND: if (w_sclk_edge && w_app_last) w_state_next = S_IDLE;
        S_CHECK:  w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge masterClk) begin
    if (!reset) begin
      r_mode          <= 1'b0;
      r_crc           <= INIT;
      r_bit_cnt       <= '0;
      r_app_cnt       <= '0;
      r_crc_out       <= 1'b0;
      r_crc_out_valid <= 1'b0;
      r_check_done    <= 1'b0;
      r_check_ok      <= 1'b0;
    end else begin
      r_check_done <= 1'b0;
      if (w_fs_edge) begin
        r_mode          <= mode;
        r_crc           <= INIT;
        r_bit_cnt       <= '0;
        r_app_cnt       <= '0;
        r_crc_out       <= 1'b0;
        r_crc_out_valid <= 1'b0;
        r_check_ok      <= 1'b0;
      end else begin
        unique case (r_state)
          S_ACCUM: begin
            if (w_sclk_edge) begin
              r_crc <= w_crc_upd;
              if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_fe_edge && !r_mode) begin
              r_crc_out_valid <= 1'b1;
              r_crc_out       <= w_crc_accum[CRC_WIDTH-1];
              r_app_cnt       <= '0;
            end
          end
          S_APPEND: begin
            if (w_sclk_edge) begin
              r_crc           <= w_shift;
              r_crc_out       <= w_shift[CRC_WIDTH-1];
              r_crc_out_valid <= !w_app_last;
              r_app_cnt       <= r_app_cnt + 1'b1;
            end
          end
          S_CHECK: begin
            r_check_done <= 1'b1;
            r_check_ok   <= (r_crc == '0);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    crc         = r_crc;
    crcOut      = r_crc_out;
    crcOutValid = r_crc_out_valid;
    bitCount    = r_bit_cnt;
    checkDone   = r_check_done;
    checkOk     = r_check_ok;
    busy        = (r_state != S_IDLE);
  end

endmodule
